// File: rtl/ppu_pkg.sv
// Shared PPU sprite-evaluation types and constants.
package ppu_pkg;

  localparam int unsigned N_SLOTS     = 8;
  localparam int unsigned N_SPR       = 64;
  localparam int unsigned EVAL_X      = 512;
  localparam int unsigned COMMIT_X    = 767;
  localparam int unsigned PRERENDER_Y = 524;
  localparam int unsigned VBL_CLR_Y   = 520;
  localparam int unsigned SPR_H_SHORT = 8;
  localparam int unsigned SPR_H_TALL  = 16;
  localparam int unsigned SLOT_W      = $clog2(N_SLOTS);
  localparam int unsigned IDX_W       = $clog2(N_SPR);

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
    logic [3:0] row;
  } spr_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RD_Y,
    CHK_Y,
    COPY,
    DONE
  } eval_state_t;

endpackage

// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluation: scans primary OAM, selects up to 8 sprites
// for the next line and commits them to a stable output set at COMMIT_X.
module sprite_eval
  import ppu_pkg::*;
(
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic [9:0]                 drx,
  input  logic [9:0]                 dry,
  input  logic                       spr_en,
  input  logic                       tall,
  output logic [7:0]                 oam_rd_addr,
  input  logic [7:0]                 oam_rd_data,
  output logic [3:0]                 spr_count,
  output logic [N_SLOTS-1:0][7:0]    spr_y,
  output logic [N_SLOTS-1:0][7:0]    spr_tile,
  output logic [N_SLOTS-1:0][7:0]    spr_attr,
  output logic [N_SLOTS-1:0][7:0]    spr_x,
  output logic [N_SLOTS-1:0][3:0]    spr_row,
  output logic                       spr0_in,
  output logic                       overflow,
  output logic                       busy
);

  eval_state_t            state;
  logic [7:0]             tgt_line;
  logic [IDX_W-1:0]       n;
  logic [1:0]             k;
  logic [3:0]             wcount;
  logic                   found0;
  spr_entry_t             work [N_SLOTS];
  logic [1:0]             cap_sel;
  logic [SLOT_W-1:0]      cap_slot;

  logic                   has_tgt_c;
  logic [7:0]             tgt_c;
  logic [8:0]             dist_c;
  logic                   in_range_c;
  logic                   last_c;
  logic                   start_c;
  logic                   commit_c;

  // Target line for the scanline being rendered next; odd VGA lines only.
  always_comb begin
    has_tgt_c = 1'b0;
    tgt_c     = 8'h00;
    if (dry == 10'(PRERENDER_Y)) begin
      has_tgt_c = 1'b1;
    end else if (dry[0] && (dry[9:1] < 9'd239)) begin
      has_tgt_c = 1'b1;
      tgt_c     = 8'(dry[9:1] + 9'd1);
    end
  end

  always_comb begin
    dist_c     = {1'b0, tgt_line} - {1'b0, oam_rd_data} - 9'd1;
    in_range_c = !dist_c[8] &&
                 (dist_c[7:0] < (tall ? 8'(SPR_H_TALL) : 8'(SPR_H_SHORT)));
    last_c     = (n == IDX_W'(N_SPR - 1));
    start_c    = (drx == 10'(EVAL_X)) && has_tgt_c;
    commit_c   = (drx == 10'(COMMIT_X));
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state       <= IDLE;
      tgt_line    <= 8'h00;
      n           <= '0;
      k           <= 2'd0;
      wcount      <= 4'd0;
      found0      <= 1'b0;
      cap_sel     <= 2'd0;
      cap_slot    <= '0;
      oam_rd_addr <= 8'h00;
      spr_count   <= 4'd0;
      spr_y       <= '0;
      spr_tile    <= '0;
      spr_attr    <= '0;
      spr_x       <= '0;
      spr_row     <= '0;
      spr0_in     <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) work[i] <= '0;
    end else begin
      // Byte read during the previous COPY cycle lands one cycle later.
      case (cap_sel)
        2'd1:    work[cap_slot].tile <= oam_rd_data;
        2'd2:    work[cap_slot].attr <= oam_rd_data;
        2'd3:    work[cap_slot].x    <= oam_rd_data;
        default: ;
      endcase
      cap_sel <= 2'd0;

      if (dry == 10'(VBL_CLR_Y)) overflow <= 1'b0;

      if (commit_c) begin
        state       <= IDLE;
        busy        <= 1'b0;
        oam_rd_addr <= 8'h00;
        if (has_tgt_c) begin
          spr_count <= wcount;
          spr0_in   <= found0;
          for (int i = 0; i < N_SLOTS; i++) begin
            if (4'(i) < wcount) begin
              spr_y[i]    <= work[i].y;
              spr_tile[i] <= work[i].tile;
              spr_attr[i] <= work[i].attr;
              spr_x[i]    <= work[i].x;
              spr_row[i]  <= work[i].row;
            end else begin
              spr_y[i]    <= 8'hFF;
              spr_tile[i] <= 8'h00;
              spr_attr[i] <= 8'h00;
              spr_x[i]    <= 8'h00;
              spr_row[i]  <= 4'h0;
            end
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (start_c) begin
              tgt_line <= tgt_c;
              if (spr_en) begin
                state <= CLEAR;
                busy  <= 1'b1;
              end else begin
                wcount <= 4'd0;
                found0 <= 1'b0;
              end
            end
          end
          CLEAR: begin
            wcount      <= 4'd0;
            n           <= '0;
            found0      <= 1'b0;
            oam_rd_addr <= 8'h00;
            state       <= RD_Y;
          end
          RD_Y: state <= CHK_Y;
          CHK_Y: begin
            if (in_range_c && (wcount < 4'(N_SLOTS))) begin
              work[wcount[SLOT_W-1:0]].y   <= oam_rd_data;
              work[wcount[SLOT_W-1:0]].row <= dist_c[3:0];
              if (n == '0) found0 <= 1'b1;
              oam_rd_addr <= {n, 2'd1};
              k           <= 2'd1;
              state       <= COPY;
            end else if (in_range_c) begin
              overflow    <= 1'b1;
              state       <= DONE;
              busy        <= 1'b0;
              oam_rd_addr <= 8'h00;
            end else if (last_c) begin
              state       <= DONE;
              busy        <= 1'b0;
              oam_rd_addr <= 8'h00;
            end else begin
              n           <= n + IDX_W'(1);
              oam_rd_addr <= {n + IDX_W'(1), 2'b00};
              state       <= RD_Y;
            end
          end
          COPY: begin
            cap_sel  <= k;
            cap_slot <= wcount[SLOT_W-1:0];
            if (k != 2'd3) begin
              k           <= k + 2'd1;
              oam_rd_addr <= {n, k + 2'd1};
            end else begin
              wcount <= wcount + 4'd1;
              if (last_c) begin
                state       <= DONE;
                busy        <= 1'b0;
                oam_rd_addr <= 8'h00;
              end else begin
                n           <= n + IDX_W'(1);
                oam_rd_addr <= {n + IDX_W'(1), 2'b00};
                state       <= RD_Y;
              end
            end
          end
          DONE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_eval.sv
// Directed self-checking bench for sprite_eval with a registered-read OAM model.
module tb_sprite_eval;

  logic                vga_clk;
  logic                reset;
  logic [9:0]          drx;
  logic [9:0]          dry;
  logic                spr_en;
  logic                tall;
  logic [7:0]          oam_rd_addr;
  logic [7:0]          oam_rd_data;
  logic [3:0]          spr_count;
  logic [7:0][7:0]     spr_y;
  logic [7:0][7:0]     spr_tile;
  logic [7:0][7:0]     spr_attr;
  logic [7:0][7:0]     spr_x;
  logic [7:0][3:0]     spr_row;
  logic                spr0_in;
  logic                overflow;
  logic                busy;

  logic [7:0] oam [256];
  int checks   = 0;
  int failures = 0;

  sprite_eval dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .drx         (drx),
    .dry         (dry),
    .spr_en      (spr_en),
    .tall        (tall),
    .oam_rd_addr (oam_rd_addr),
    .oam_rd_data (oam_rd_data),
    .spr_count   (spr_count),
    .spr_y       (spr_y),
    .spr_tile    (spr_tile),
    .spr_attr    (spr_attr),
    .spr_x       (spr_x),
    .spr_row     (spr_row),
    .spr0_in     (spr0_in),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Primary OAM: data valid one cycle after the address.
  always @(posedge vga_clk) oam_rd_data <= oam[oam_rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_span(input logic [9:0] line, input int from, input int to);
    for (int x = from; x <= to; x++) begin
      dry = line;
      drx = 10'(x);
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic run_line(input logic [9:0] line);
    run_span(line, 0, 799);
  endtask

  task automatic oam_fill_ff();
    for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
  endtask

  task automatic set_spr(input int n, input logic [7:0] y, input logic [7:0] tile,
                         input logic [7:0] attr, input logic [7:0] x);
    oam[4*n]     = y;
    oam[4*n + 1] = tile;
    oam[4*n + 2] = attr;
    oam[4*n + 3] = x;
  endtask

  initial begin
    reset  = 1'b1;
    spr_en = 1'b1;
    tall   = 1'b0;
    drx    = 10'd0;
    dry    = 10'd0;
    oam_fill_ff();
    run_span(10'd0, 0, 1);
    reset = 1'b0;
    chk("rst_count", 64'(spr_count), 64'h0);
    chk("rst_y", 64'(spr_y), 64'h0);
    chk("rst_ovf", 64'(overflow), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_spr0", 64'(spr0_in), 64'h0);
    chk("rst_addr", 64'(oam_rd_addr), 64'h0);

    // Sprite 0 on line 17 (row 1).
    set_spr(0, 8'h0F, 8'hA1, 8'h42, 8'h37);
    run_span(10'd33, 0, 520);
    chk("t1_busy_mid", 64'(busy), 64'h1);
    run_span(10'd33, 521, 799);
    chk("t1_count", 64'(spr_count), 64'd1);
    chk("t1_y0", 64'(spr_y[0]), 64'h0F);
    chk("t1_tile0", 64'(spr_tile[0]), 64'hA1);
    chk("t1_attr0", 64'(spr_attr[0]), 64'h42);
    chk("t1_x0", 64'(spr_x[0]), 64'h37);
    chk("t1_row0", 64'(spr_row[0]), 64'd1);
    chk("t1_spr0", 64'(spr0_in), 64'h1);
    chk("t1_ovf", 64'(overflow), 64'h0);
    chk("t1_y1_unused", 64'(spr_y[1]), 64'hFF);
    chk("t1_tile1_unused", 64'(spr_tile[1]), 64'h0);
    chk("t1_busy_end", 64'(busy), 64'h0);

    // Ten sprites on line 0x21: first eight kept, ninth raises overflow.
    oam_fill_ff();
    for (int n = 3; n <= 12; n++) set_spr(n, 8'h20, 8'(n), 8'(8'h10 + n), 8'(8'h80 + n));
    run_span(10'd65, 0, 511);
    chk("t2_ovf_before", 64'(overflow), 64'h0);
    run_span(10'd65, 512, 600);
    chk("t2_ovf_found", 64'(overflow), 64'h1);
    chk("t2_busy_done", 64'(busy), 64'h0);
    run_span(10'd65, 601, 799);
    chk("t2_count", 64'(spr_count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_y%0d", i), 64'(spr_y[i]), 64'h20);
      chk($sformatf("t2_tile%0d", i), 64'(spr_tile[i]), 64'(3 + i));
      chk($sformatf("t2_x%0d", i), 64'(spr_x[i]), 64'(8'h80 + 3 + i));
    end
    chk("t2_attr7", 64'(spr_attr[7]), 64'h1A);
    chk("t2_row0", 64'(spr_row[0]), 64'd0);
    chk("t2_spr0", 64'(spr0_in), 64'h0);
    chk("t2_ovf", 64'(overflow), 64'h1);
    run_line(10'd520);
    chk("t2_ovf_clr", 64'(overflow), 64'h0);
    chk("t2_held_count", 64'(spr_count), 64'd8);

    // 8x16 boundaries on sprite 5 at Y=0x40.
    oam_fill_ff();
    set_spr(5, 8'h40, 8'h55, 8'hC3, 8'h99);
    tall = 1'b1;
    run_line(10'd159);
    chk("t3_tall_count", 64'(spr_count), 64'd1);
    chk("t3_tall_row", 64'(spr_row[0]), 64'd15);
    chk("t3_tall_tile", 64'(spr_tile[0]), 64'h55);
    chk("t3_tall_spr0", 64'(spr0_in), 64'h0);
    run_line(10'd161);
    chk("t3_tall_past", 64'(spr_count), 64'd0);
    chk("t3_tall_past_y", 64'(spr_y[0]), 64'hFF);
    tall = 1'b0;
    run_line(10'd145);
    chk("t3_short_past", 64'(spr_count), 64'd0);
    run_line(10'd143);
    chk("t3_short_last", 64'(spr_count), 64'd1);
    chk("t3_short_row", 64'(spr_row[0]), 64'd7);

    // Sprites disabled: no scan, empty commit.
    spr_en = 1'b0;
    run_span(10'd143, 0, 600);
    chk("t4_addr_idle", 64'(oam_rd_addr), 64'h0);
    chk("t4_busy", 64'(busy), 64'h0);
    run_span(10'd143, 601, 799);
    chk("t4_count", 64'(spr_count), 64'd0);
    chk("t4_ovf", 64'(overflow), 64'h0);

    // Reset in the middle of a scan.
    spr_en = 1'b1;
    run_span(10'd143, 0, 599);
    chk("t5_busy_pre", 64'(busy), 64'h1);
    reset = 1'b1;
    run_span(10'd143, 600, 600);
    reset = 1'b0;
    chk("t5_count", 64'(spr_count), 64'h0);
    chk("t5_y", 64'(spr_y), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_addr", 64'(oam_rd_addr), 64'h0);
    chk("t5_ovf", 64'(overflow), 64'h0);
    run_span(10'd143, 601, 799);
    run_line(10'd143);
    chk("t5_next_count", 64'(spr_count), 64'd1);
    chk("t5_next_row", 64'(spr_row[0]), 64'd7);
    chk("t5_next_x", 64'(spr_x[0]), 64'h99);

    // Pre-render line targets line 0; Y=0 only appears from line 1.
    oam_fill_ff();
    set_spr(2, 8'h00, 8'h22, 8'h01, 8'h10);
    run_line(10'd524);
    chk("t6_t0_count", 64'(spr_count), 64'd0);
    chk("t6_t0_y", 64'(spr_y[0]), 64'hFF);
    run_line(10'd1);
    chk("t6_t1_count", 64'(spr_count), 64'd1);
    chk("t6_t1_y", 64'(spr_y[0]), 64'h00);
    chk("t6_t1_row", 64'(spr_row[0]), 64'd0);
    chk("t6_t1_tile", 64'(spr_tile[0]), 64'h22);
    chk("t6_t1_spr0", 64'(spr0_in), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
